// File: rtl/fft_frame_sched_if.sv
// Control bundle between the frame scheduler and its two requesters plus the FFT wrapper.
// o_state mirrors the scheduler FSM state for observation only.
interface fft_frame_sched_if;
  // Handshake: a requester raises its level request and holds it until its one-cycle
  // done pulse; it drops the request in the following cycle or it is taken as a new request.
  // The wrapper sees one o_start pulse per frame and answers with one i_fft_finish pulse.
  logic       i_fft_req;
  logic       i_ifft_req;
  logic       o_fft_done;
  logic       o_ifft_done;
  logic       o_mode;
  logic       o_start;
  logic       i_fft_finish;
  logic       o_busy;
  logic       o_timeout;
  logic [2:0] o_state;

  modport slave (
    input  i_fft_req, i_ifft_req, i_fft_finish,
    output o_fft_done, o_ifft_done, o_mode, o_start, o_busy, o_timeout, o_state
  );

  modport master (
    output i_fft_req, i_ifft_req, i_fft_finish,
    input  o_fft_done, o_ifft_done, o_mode, o_start, o_busy, o_timeout, o_state
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Frame scheduler for the FFT/IFFT engine: round-robin grant, settle, start, wait, done.
// Optional WAIT watchdog and o_timeout are built when FFT_SCHED_TIMEOUT_EN is defined.
module fft_frame_sched #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  fft_frame_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("fft_frame_sched: parameter out of range");
  end

  state_t     state_q;
  logic       last_fft_q;
  logic       mode_q;
  logic       start_q;
  logic       fft_done_q;
  logic       ifft_done_q;
  logic       busy_q;
  logic       timeout_q;
  logic [7:0] settle_cnt_q;
  logic       req_any;
  logic       grant_fft_d;

  // A tie goes to FFT unless the previous grant was FFT.
  always_comb begin
    req_any     = bus.i_fft_req | bus.i_ifft_req;
    grant_fft_d = 1'b0;
    if (bus.i_fft_req && bus.i_ifft_req) grant_fft_d = ~last_fft_q;
    else if (bus.i_fft_req)              grant_fft_d = 1'b1;
  end

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      last_fft_q   <= 1'b0;
      mode_q       <= 1'b1;
      start_q      <= 1'b0;
      fft_done_q   <= 1'b0;
      ifft_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      settle_cnt_q <= 8'd0;
`ifdef FFT_SCHED_TIMEOUT_EN
      wait_cnt_q   <= 16'd0;
`endif
    end else begin
      start_q     <= 1'b0;
      fft_done_q  <= 1'b0;
      ifft_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            state_q      <= ST_SETTLE;
            mode_q       <= grant_fft_d;
            last_fft_q   <= grant_fft_d;
            settle_cnt_q <= 8'd0;
            busy_q       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= ST_START;
            start_q <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
`ifdef FFT_SCHED_TIMEOUT_EN
          wait_cnt_q <= 16'd0;
`endif
        end
        ST_WAIT: begin
          // Finish takes priority over the watchdog when both land together.
          if (bus.i_fft_finish) begin
            state_q     <= ST_DONE;
            fft_done_q  <= mode_q;
            ifft_done_q <= ~mode_q;
          end
`ifdef FFT_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == TIMEOUT_LAST) begin
            state_q     <= ST_DONE;
            fft_done_q  <= mode_q;
            ifft_done_q <= ~mode_q;
            timeout_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_mode      = mode_q;
  assign bus.o_start     = start_q;
  assign bus.o_fft_done  = fft_done_q;
  assign bus.o_ifft_done = ifft_done_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_state     = state_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: reset, single frame, tie arbitration, back-to-back,
// mid-frame reset, and (with FFT_SCHED_TIMEOUT_EN) watchdog behaviour.
module tb_fft_frame_sched;
  localparam int S = 4;
  localparam int T = 100;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_frame_sched_if bus();

  fft_frame_sched #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    bus.i_fft_req = 1'b0;
    bus.i_ifft_req = 1'b0;
    bus.i_fft_finish = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.i_fft_req = 1'b0;
    bus.i_ifft_req = 1'b0;
    bus.i_fft_finish = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.o_fft_done, bus.o_ifft_done, bus.o_start, bus.o_busy, bus.o_timeout, bus.o_mode} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000001",
               {bus.o_fft_done, bus.o_ifft_done, bus.o_start, bus.o_busy, bus.o_timeout, bus.o_mode});
    end
    rstn = 1'b1;
    step();
    checks++;
    if (bus.o_state !== 3'd0 || bus.o_mode !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d mode=%b busy=%b expected 0 1 0", bus.o_state, bus.o_mode, bus.o_busy);
    end
    bus.i_fft_finish = 1'b1;
    step();
    bus.i_fft_finish = 1'b0;
    step();
    checks++;
    if (bus.o_fft_done !== 1'b0 || bus.o_ifft_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_finish_ignored: fft_done=%b ifft_done=%b busy=%b expected 0 0 0",
               bus.o_fft_done, bus.o_ifft_done, bus.o_busy);
    end
  endtask

  task automatic test_single_fft();
    int n;
    bit bad;
    bus.i_fft_req = 1'b1;
    step();
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_mode !== 1'b1 || bus.o_start !== 1'b0 || bus.o_state !== 3'd1) begin
      errors++;
      $display("FAIL fft_settle_entry: busy=%b mode=%b start=%b state=%0d expected 1 1 0 1",
               bus.o_busy, bus.o_mode, bus.o_start, bus.o_state);
    end
    n = 0;
    while (bus.o_start !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n != S) begin
      errors++;
      $display("FAIL fft_start_latency: got %0d cycles expected %0d", n, S);
    end
    step();
    checks++;
    if (bus.o_start !== 1'b0 || bus.o_state !== 3'd3) begin
      errors++;
      $display("FAIL fft_start_width: start=%b state=%0d expected 0 3", bus.o_start, bus.o_state);
    end
    bad = 1'b0;
    repeat (20) begin
      step();
      if (bus.o_fft_done !== 1'b0 || bus.o_start !== 1'b0 || bus.o_busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fft_wait_quiet: got activity in WAIT expected none");
    end
    bus.i_fft_finish = 1'b1;
    step();
    bus.i_fft_finish = 1'b0;
    checks++;
    if (bus.o_fft_done !== 1'b1 || bus.o_ifft_done !== 1'b0 || bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL fft_done_pulse: fft=%b ifft=%b to=%b busy=%b expected 1 0 0 1",
               bus.o_fft_done, bus.o_ifft_done, bus.o_timeout, bus.o_busy);
    end
    bus.i_fft_req = 1'b0;
    step();
    checks++;
    if (bus.o_fft_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL fft_back_idle: done=%b busy=%b state=%0d expected 0 0 0",
               bus.o_fft_done, bus.o_busy, bus.o_state);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    bit bad;
    apply_reset();
    bus.i_fft_req = 1'b1;
    bus.i_ifft_req = 1'b1;
    for (int f = 0; f < 2; f++) begin
      logic exp_mode;
      exp_mode = (f == 0) ? 1'b1 : 1'b0;
      step();
      checks++;
      if (bus.o_mode !== exp_mode || bus.o_busy !== 1'b1) begin
        errors++;
        $display("FAIL tie_grant_%0d: mode=%b busy=%b expected %b 1", f, bus.o_mode, bus.o_busy, exp_mode);
      end
      bad = 1'b0;
      n = 0;
      while (bus.o_start !== 1'b1 && n < 20) begin
        step();
        n++;
        if (bus.o_mode !== exp_mode) bad = 1'b1;
      end
      step();
      if (bus.o_mode !== exp_mode) bad = 1'b1;
      bus.i_fft_finish = 1'b1;
      step();
      bus.i_fft_finish = 1'b0;
      if (bus.o_mode !== exp_mode) bad = 1'b1;
      checks++;
      if (bad || n != S) begin
        errors++;
        $display("FAIL tie_mode_stable_%0d: latency=%0d unstable=%b expected %0d 0", f, n, bad, S);
      end
      checks++;
      if (bus.o_fft_done !== exp_mode || bus.o_ifft_done !== ~exp_mode) begin
        errors++;
        $display("FAIL tie_done_%0d: fft=%b ifft=%b expected %b %b", f, bus.o_fft_done, bus.o_ifft_done,
                 exp_mode, ~exp_mode);
      end
      if (f == 0) bus.i_fft_req = 1'b0;
      else        bus.i_ifft_req = 1'b0;
      step();
    end
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_mode !== 1'b0) begin
      errors++;
      $display("FAIL tie_final_idle: busy=%b mode=%b expected 0 0", bus.o_busy, bus.o_mode);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int t1;
    int t2;
    bus.i_ifft_req = 1'b1;
    n = 0;
    while (bus.o_start !== 1'b1 && n < 20) begin step(); n++; end
    t1 = cyc;
    step();
    bus.i_fft_finish = 1'b1;
    step();
    bus.i_fft_finish = 1'b0;
    checks++;
    if (bus.o_ifft_done !== 1'b1 || bus.o_mode !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done: ifft_done=%b mode=%b expected 1 0", bus.o_ifft_done, bus.o_mode);
    end
    n = 0;
    while (bus.o_start !== 1'b1 && n < 20) begin step(); n++; end
    t2 = cyc;
    checks++;
    if (t2 - t1 != S + 4) begin
      errors++;
      $display("FAIL b2b_start_spacing: got %0d expected %0d", t2 - t1, S + 4);
    end
    step();
    bus.i_fft_finish = 1'b1;
    step();
    bus.i_fft_finish = 1'b0;
    bus.i_ifft_req = 1'b0;
    checks++;
    if (bus.o_ifft_done !== 1'b1 || bus.o_fft_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done: ifft=%b fft=%b expected 1 0", bus.o_ifft_done, bus.o_fft_done);
    end
    step();
    step();
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b expected 0", bus.o_busy);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bus.i_fft_req = 1'b1;
    n = 0;
    while (bus.o_start !== 1'b1 && n < 20) begin step(); n++; end
    step();
    step();
    bus.i_fft_req = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_state !== 3'd0 || bus.o_mode !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: busy=%b state=%0d mode=%b expected 0 0 1", bus.o_busy, bus.o_state, bus.o_mode);
    end
    step();
    rstn = 1'b1;
    step();
    bus.i_fft_finish = 1'b1;
    step();
    bus.i_fft_finish = 1'b0;
    step();
    checks++;
    if (bus.o_fft_done !== 1'b0 || bus.o_ifft_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_finish_ignored: fft=%b ifft=%b busy=%b expected 0 0 0",
               bus.o_fft_done, bus.o_ifft_done, bus.o_busy);
    end
  endtask

`ifdef FFT_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bus.i_fft_req = 1'b1;
    n = 0;
    while (bus.o_start !== 1'b1 && n < 20) begin step(); n++; end
    step();
    n = 0;
    while (bus.o_fft_done !== 1'b1 && n < 3 * T) begin step(); n++; end
    bus.i_fft_req = 1'b0;
    checks++;
    if (n != T || bus.o_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles timeout=%b expected %0d 1", n, bus.o_timeout, T);
    end
    step();
    step();
    bus.i_fft_finish = 1'b1;
    step();
    bus.i_fft_finish = 1'b0;
    step();
    checks++;
    if (bus.o_fft_done !== 1'b0 || bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_finish: done=%b to=%b busy=%b expected 0 0 0",
               bus.o_fft_done, bus.o_timeout, bus.o_busy);
    end
  endtask

  task automatic test_collision();
    int n;
    bus.i_fft_req = 1'b1;
    n = 0;
    while (bus.o_start !== 1'b1 && n < 20) begin step(); n++; end
    step();
    repeat (T - 1) step();
    bus.i_fft_finish = 1'b1;
    step();
    bus.i_fft_finish = 1'b0;
    bus.i_fft_req = 1'b0;
    checks++;
    if (bus.o_fft_done !== 1'b1 || bus.o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL collision_finish_wins: done=%b to=%b expected 1 0", bus.o_fft_done, bus.o_timeout);
    end
    step();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.i_fft_req = 1'b0;
    bus.i_ifft_req = 1'b0;
    bus.i_fft_finish = 1'b0;
    test_reset();
    test_single_fft();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
`ifdef FFT_SCHED_TIMEOUT_EN
    test_timeout();
    test_collision();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
